sm83_bus_fabric: RTL and testbench
==================================

# sm83_bus_fabric

Parametrised memory-map fabric between `sm83_core` and up to `NUM_REGIONS` memory/peripheral targets. It replaces fixed address-compare glue with a per-region base/limit decoder, a per-region programmable wait-state counter, and read-only protection. It also adds a completion handshake, so slow targets can stall the core. Targets are synchronous-read with one-cycle read latency.

## Interface
- `NUM_REGIONS`, default 4: number of target regions (1–8).
- `ADDR_W`, default 16: address width.
- `DATA_W`, default 8: data width.
- `REGION_BASE`, default {16'hFF80,16'hA000,16'hC000,16'h0000}: flattened `NUM_REGIONS*ADDR_W`; slice i is the inclusive base of region i.
- `REGION_LIMIT`, default {16'hFFFE,16'hBFFF,16'hDFFF,16'h7FFF}: flattened; slice i is the inclusive limit of region i.
- `REGION_WAIT`, default {4'd0,4'd1,4'd2,4'd0}: flattened `NUM_REGIONS*4`; wait states for region i.
- `REGION_RO`, default 4'b0001: bit i set makes region i read-only.
- `OPEN_BUS`, default 8'hFF: read value for unmapped addresses.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present; sampled only in IDLE.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  request address.
- `req_wdata`  in  DATA_W  write data.
- `req_ready`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  DATA_W  read data; valid when `req_ready`=1, held afterwards.
- `rsp_fault`  out  1  fault flag, valid with `req_ready`.
- `mem_en`  out  NUM_REGIONS  one-hot target strobe.
- `mem_we`  out  NUM_REGIONS  one-hot write enable (subset of `mem_en`).
- `mem_addr`  out  ADDR_W  local offset, `addr - REGION_BASE[sel]`, modulo 2^ADDR_W.
- `mem_wdata`  out  DATA_W  captured write data.
- `mem_rdata`  in  NUM_REGIONS*DATA_W  per-region read data, returned one cycle after `mem_en`.

## Operation
- **FSM states:** IDLE, WAIT, STROBE, RESP.
- **IDLE:**
  - If `req_valid`=1, capture `req_we`, `req_addr` and `req_wdata`, and decode the address.
  - A hit is `BASE <= addr <= LIMIT`. The lowest-index hit wins when regions overlap.
  - Capture the region index, load `wcnt` = `REGION_WAIT[sel]`.
  - Go to WAIT if `wcnt` != 0, otherwise go to STROBE.
- **Unmapped address:** go directly to RESP with the fault set. No `mem_en` is issued.
- **WAIT:** decrement `wcnt` each cycle; go to STROBE when it reaches 1.
- **STROBE:**
  - `mem_en[sel]`=1 for exactly one cycle.
  - `mem_we[sel]` = captured write flag AND NOT `REGION_RO[sel]`.
  - A write to a read-only region still issues `mem_en` but no `mem_we`, and sets the fault.
- **RESP:**
  - `req_ready`=1.
  - `rsp_rdata` is the `mem_rdata` slice of `sel` for a mapped read, `OPEN_BUS` for an unmapped read, and the held value for writes.
  - The hold register loads `rsp_rdata` in this cycle.
  - Always return to IDLE.
- **Request capture:** request inputs are ignored outside IDLE. A requester holding `req_valid` high after `req_ready` starts a new transaction in the following IDLE cycle.
- **Idle outputs:** `mem_addr` and `mem_wdata` are driven from captured registers. Every output except `rsp_rdata` is 0 whenever the FSM is in IDLE or WAIT.

## Timing
- **Reset values:** state IDLE, `wcnt`=0, captured registers 0, hold register = `OPEN_BUS`, all outputs 0 except `rsp_rdata`=`OPEN_BUS`.
- **Mapped access:** request accepted at edge T. STROBE occupies cycle T+1+W, RESP occupies cycle T+2+W, and the next acceptance is no earlier than T+3+W. W is the region's wait count.
- **Unmapped access:** RESP at cycle T+1; next acceptance at T+2.
- **Throughput:** one transaction in flight at a time; no pipelining.
- **Reset mid-transaction:** returns to IDLE immediately. A pending `mem_en`/`mem_we` drops asynchronously and no `req_ready` is issued for the aborted transaction.
- **Wrap-around:** `mem_addr` subtraction wraps modulo 2^ADDR_W. A region whose limit is 16'hFFFF is legal.

## Configuration
- **`SM83_BUS_FAULT_EN` defined:** `rsp_fault`=1 in RESP for unmapped accesses and read-only writes; otherwise 0.
- **`SM83_BUS_FAULT_EN` undefined:** `rsp_fault` is tied to 0. Unmapped reads still return `OPEN_BUS`, and read-only writes are still silently dropped (no `mem_we`).

## Test plan
- Reset asserted mid-WAIT on a region 1 write → all `mem_en`/`mem_we`=0 at once, no `req_ready`, `rsp_rdata`=8'hFF, next request accepted normally.
- Read 16'h0150 (region 0, W=0), with `mem_rdata` slice 0 = 8'h3E one cycle after strobe → `mem_en`=4'b0001 at T+1, `mem_addr`=16'h0150, `req_ready` at T+2 with `rsp_rdata`=8'h3E and `rsp_fault`=0.
- Write 8'h5A to 16'hC010 (region 1, W=2) → `mem_en`=`mem_we`=4'b0010 only at T+3, `mem_addr`=16'h0010, `mem_wdata`=8'h5A, `req_ready` at T+4.
- Write 8'h77 to 16'h2000 (region 0, read-only) → `mem_en`=4'b0001, `mem_we`=0. `rsp_fault`=1 with the macro and 0 without it; `rsp_rdata` holds its previous value.
- Read 16'hE000 (unmapped) → no `mem_en`, `req_ready` at T+1, `rsp_rdata`=8'hFF, `rsp_fault`=1 with the macro.
- `req_valid` held high across back-to-back reads of 16'hFF80 (W=0) → acceptances every 3 cycles, `mem_en`=4'b1000, `mem_addr`=16'h0000.

Source files
------------

// File: rtl/sm83_bus_fabric.sv
// sm83_bus_fabric: memory-map fabric between the SM83 core and up to
// NUM_REGIONS synchronous-read targets. Each region has an inclusive
// base/limit window, a programmable wait-state count and an optional
// read-only attribute. One transaction is in flight at a time; the core
// is stalled until the one-cycle req_ready completion pulse.
//
// Handshake: req_valid is sampled only while the FSM is IDLE. The
// request fields are captured on that edge and ignored afterwards.
// req_ready pulses for exactly one cycle (RESP). rsp_rdata and rsp_fault
// are valid in that cycle; rsp_rdata then holds its value until the next
// RESP. Holding req_valid high through req_ready starts the next
// transaction in the following IDLE cycle.
//
// Optional feature: define SM83_BUS_FAULT_EN to report unmapped accesses
// and read-only writes on rsp_fault. Without it rsp_fault is tied low.
// The internal FSM state is the `state` signal (state_t) for probing.
module sm83_bus_fabric #(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
        {16'hFF80, 16'hA000, 16'hC000, 16'h0000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT =
        {16'hFFFE, 16'hBFFF, 16'hDFFF, 16'h7FFF},
    parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT = {4'd0, 4'd1, 4'd2, 4'd0},
    parameter logic [NUM_REGIONS-1:0] REGION_RO = 4'b0001,
    parameter logic [DATA_W-1:0] OPEN_BUS = 8'hFF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    input  logic                          req_we,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    output logic                          req_ready,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_fault,
    output logic [NUM_REGIONS-1:0]        mem_en,
    output logic [NUM_REGIONS-1:0]        mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [NUM_REGIONS*DATA_W-1:0] mem_rdata
);

    localparam int SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STROBE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Captured transaction
    logic              we_q;
    logic              hit_q;
    logic [SEL_W-1:0]  sel_q;
    logic [ADDR_W-1:0] off_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wcnt;
    logic [DATA_W-1:0] hold_q;

    // Decoder results for the live request address
    logic              dec_hit;
    logic [SEL_W-1:0]  dec_sel;
    logic [3:0]        dec_wait;
    logic [ADDR_W-1:0] dec_base;

    // Attributes of the captured region
    logic                   sel_ro;
    logic [DATA_W-1:0]      sel_rdata;
    logic [NUM_REGIONS-1:0] sel_onehot;
    logic [DATA_W-1:0]      rdata_mux;

    // Address decode: scan high to low so the lowest-index hit wins on overlap
    always_comb begin
        dec_hit  = 1'b0;
        dec_sel  = '0;
        dec_wait = '0;
        dec_base = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (req_addr >= REGION_BASE[i*ADDR_W +: ADDR_W] &&
                req_addr <= REGION_LIMIT[i*ADDR_W +: ADDR_W]) begin
                dec_hit  = 1'b1;
                dec_sel  = SEL_W'(i);
                dec_wait = REGION_WAIT[i*4 +: 4];
                dec_base = REGION_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Per-region view of the captured selection: strobe mask, RO bit, read data
    always_comb begin
        sel_ro     = 1'b0;
        sel_rdata  = '0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_ro        = REGION_RO[i];
                sel_rdata     = mem_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic; WAIT runs for exactly the region's wait count
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!dec_hit) begin
                        state_next = RESP;
                    end else if (dec_wait != 4'd0) begin
                        state_next = WAIT;
                    end else begin
                        state_next = STROBE;
                    end
                end
            end
            WAIT: begin
                if (wcnt <= 4'd1) begin
                    state_next = STROBE;
                end
            end
            STROBE:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, request capture, wait counter and read-data hold register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            sel_q   <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            wcnt    <= 4'd0;
            hold_q  <= OPEN_BUS;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        hit_q   <= dec_hit;
                        sel_q   <= dec_sel;
                        off_q   <= req_addr - dec_base;
                        wdata_q <= req_wdata;
                        wcnt    <= dec_hit ? dec_wait : 4'd0;
                    end
                end
                WAIT: begin
                    wcnt <= wcnt - 4'd1;
                end
                RESP: begin
                    hold_q <= rdata_mux;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: everything but rsp_rdata stays low in IDLE and WAIT
    always_comb begin
        req_ready = 1'b0;
        mem_en    = '0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        rdata_mux = hold_q;
        case (state)
            STROBE: begin
                mem_en    = sel_onehot;
                mem_we    = (we_q && !sel_ro) ? sel_onehot : '0;
                mem_addr  = off_q;
                mem_wdata = wdata_q;
            end
            RESP: begin
                req_ready = 1'b1;
                mem_addr  = off_q;
                mem_wdata = wdata_q;
                if (!we_q) begin
                    rdata_mux = hit_q ? sel_rdata : OPEN_BUS;
                end
            end
            default: begin
            end
        endcase
    end

    assign rsp_rdata = rdata_mux;

`ifdef SM83_BUS_FAULT_EN
    // Fault on unmapped access or on a write into a read-only region
    assign rsp_fault = (state == RESP) && (!hit_q || (we_q && sel_ro));
`else
    assign rsp_fault = 1'b0;
`endif

endmodule

// File: tb/tb_sm83_bus_fabric.sv
// Self-checking bench for sm83_bus_fabric (default parameters).
// Expected strobes and responses, stamped with the cycle they must appear
// in, are queued when a request is driven and compared by a monitor on
// the falling edge.
module tb_sm83_bus_fabric;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready;
  logic [7:0]  rsp_rdata;
  logic        rsp_fault;
  logic [3:0]  mem_en;
  logic [3:0]  mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference memory map
  logic [15:0] m_base[4]  = '{16'h0000, 16'hC000, 16'hA000, 16'hFF80};
  logic [15:0] m_limit[4] = '{16'h7FFF, 16'hDFFF, 16'hBFFF, 16'hFFFE};
  int          m_wait[4]  = '{0, 2, 1, 0};
  logic        m_ro[4]    = '{1'b1, 1'b0, 1'b0, 1'b0};

  // stb entry: {cyc[31:0], en[3:0], we[3:0], addr[15:0], wdata[7:0]}
  logic [63:0] stb_q[$];
  // rsp entry: {cyc[31:0], rdata[7:0], fault}
  logic [40:0] rsp_q[$];
  logic [7:0]  last_rd;

  sm83_bus_fabric dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_fault (rsp_fault),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_fault(input logic hit, input logic we, input int sel);
`ifdef SM83_BUS_FAULT_EN
    return !hit || (we && m_ro[sel]);
`else
    return 1'b0;
`endif
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [63:0] se;
    logic [40:0] re;
    if (!rst) begin
      if (mem_en != 4'd0 || mem_we != 4'd0) begin
        if (stb_q.size() == 0) begin
          check("stb_unexpected", 32'({mem_en, mem_we}), 32'd0);
        end else begin
          se = stb_q.pop_front();
          check("stb_cyc", 32'(cyc), se[63:32]);
          check("mem_en", 32'(mem_en), 32'(se[31:28]));
          check("mem_we", 32'(mem_we), 32'(se[27:24]));
          check("mem_addr", 32'(mem_addr), 32'(se[23:8]));
          check("mem_wdata", 32'(mem_wdata), 32'(se[7:0]));
        end
      end
      if (req_ready) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 32'(req_ready), 32'd0);
        end else begin
          re = rsp_q.pop_front();
          check("rsp_cyc", 32'(cyc), re[40:9]);
          check("rsp_rdata", 32'(rsp_rdata), 32'(re[8:1]));
          check("rsp_fault", 32'(rsp_fault), 32'(re[0]));
        end
      end else begin
        check("fault_idle", 32'(rsp_fault), 32'd0);
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || stb_q.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(rsp_q.size() + stb_q.size()), 32'd0);
    rsp_q.delete();
    stb_q.delete();
    @(posedge clk);
  endtask

  // driver: one request, expectations derived from the reference map
  task automatic do_req(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                        input logic [31:0] rdv);
    logic       hit;
    int         sel;
    int         t;
    logic [3:0] en;
    logic [3:0] web;
    logic [7:0] rd;
    hit = 1'b0;
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      if (!hit && addr >= m_base[i] && addr <= m_limit[i]) begin
        hit = 1'b1;
        sel = i;
      end
    end
    @(negedge clk);
    mem_rdata = rdv;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    t = cyc;
    req_valid = 1'b0;
    if (we) rd = last_rd;
    else if (hit) rd = rdv[sel*8 +: 8];
    else rd = 8'hFF;
    if (hit) begin
      en  = 4'(1 << sel);
      web = (we && !m_ro[sel]) ? en : 4'd0;
      stb_q.push_back({32'(t + m_wait[sel]), en, web, 16'(addr - m_base[sel]), wd});
      rsp_q.push_back({32'(t + m_wait[sel] + 1), rd, exp_fault(hit, we, sel)});
    end else begin
      rsp_q.push_back({32'(t), rd, exp_fault(hit, we, sel)});
    end
    last_rd = rd;
    drain();
  endtask

  // req_valid held high across n back-to-back reads of FF80
  task automatic b2b(input int n, input logic [31:0] rdv);
    int t0;
    @(negedge clk);
    mem_rdata = rdv;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'hFF80;
    req_wdata = 8'h00;
    @(posedge clk);
    #1;
    t0 = cyc;
    for (int k = 0; k < n; k++) begin
      stb_q.push_back({32'(t0 + 3*k), 4'b1000, 4'b0000, 16'h0000, 8'h00});
      rsp_q.push_back({32'(t0 + 3*k + 1), rdv[31:24], 1'b0});
    end
    last_rd = rdv[31:24];
    repeat (3*(n-1)) @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain();
  endtask

  // reset pulse while a region 1 write sits in WAIT (mid=1) or STROBE (mid=0)
  task automatic reset_abort(input bit in_wait);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'hC010;
    req_wdata = 8'hA5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (in_wait) begin
      @(posedge clk);
      #1;
      check("pre_rst_wait_en", 32'(mem_en), 32'd0);
    end else begin
      repeat (2) @(posedge clk);
      #1;
      check("pre_rst_strobe_en", 32'(mem_en), 32'h2);
    end
    #1;
    rst = 1'b1;
    #1;
    check("abort_mem_en", 32'(mem_en), 32'd0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
    check("abort_rdata", 32'(rsp_rdata), 32'hFF);
    last_rd = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [15:0] bnd_addr[10];
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 16'h0;
    req_wdata = 8'h0;
    mem_rdata = 32'h0;
    last_rd   = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'hFF);
    check("rst_fault", 32'(rsp_fault), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    reset_abort(1'b1);
    do_req(1'b0, 16'h0150, 8'h00, 32'h1122_333E);
    do_req(1'b1, 16'hC010, 8'h5A, 32'h0);
    do_req(1'b1, 16'h2000, 8'h77, 32'h0);
    do_req(1'b0, 16'hE000, 8'h00, 32'h4444_4444);
    b2b(3, 32'hC700_0000);
    reset_abort(1'b0);
    do_req(1'b0, 16'hA123, 8'h00, 32'h0099_0000);
    do_req(1'b1, 16'hE000, 8'h12, 32'h0);

    bnd_addr = '{16'h7FFF, 16'h8000, 16'h9FFF, 16'hA000, 16'hBFFF,
                 16'hC000, 16'hDFFF, 16'hFF7F, 16'hFFFE, 16'hFFFF};
    foreach (bnd_addr[i]) begin
      do_req(1'b0, bnd_addr[i], 8'h00, $urandom());
    end

    for (int k = 0; k < 24; k++) begin
      do_req(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
             8'($urandom_range(0, 255)), $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
